// File: rtl/clock_freq_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_freq_monitor_if
// Brief    : Control and result bundle for one clock frequency monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface clock_freq_monitor_if #(
    parameter int CNT_WIDTH = 20
);
    logic                 enable;
    logic                 meas_toggle;
    logic [CNT_WIDTH-1:0] count_out;
    logic                 count_valid;
    logic                 freq_ok;
    logic                 freq_low;
    logic                 freq_high;
    logic                 stuck;

    // master: the monitor itself; slave: the status/health consumer
    modport master (
        input  enable, meas_toggle,
        output count_out, count_valid, freq_ok, freq_low, freq_high, stuck
    );

    modport slave (
        output enable, meas_toggle,
        input  count_out, count_valid, freq_ok, freq_low, freq_high, stuck
    );
endinterface
`default_nettype wire

// File: rtl/clock_freq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clock_freq_monitor
// Brief    : Counts edges of an asynchronous toggle over a fixed clk_125mhz
//            window and classifies the rate. FREQ_MON_HYST_EN filters freq_ok.
// Revision : 1.0 - initial release
// ============================================================================
module clock_freq_monitor #(
    parameter int GATE_CYCLES = 125000,
    parameter int CNT_WIDTH   = 20,
    parameter int EXPECT_MIN  = 0,
    parameter int EXPECT_MAX  = 2**CNT_WIDTH - 1,
    parameter int SYNC_STAGES = 3
) (
    input  wire logic            clk_125mhz,
    input  wire logic            rst_n,
    clock_freq_monitor_if.master mon
);

    localparam int                   c_gate_w    = $clog2(GATE_CYCLES);
    localparam logic [c_gate_w-1:0]  c_gate_last = c_gate_w'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH:0]   c_exp_min   = (CNT_WIDTH + 1)'(EXPECT_MIN);
    localparam logic [CNT_WIDTH:0]   c_exp_max   = (CNT_WIDTH + 1)'(EXPECT_MAX);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_gate   = 2'd1;
    localparam logic [1:0] c_st_report = 2'd2;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic                   w_edge;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic                   w_in_gate;
    logic                   w_in_report;

    logic [c_gate_w-1:0]    r_gate_cnt;
    logic [CNT_WIDTH-1:0]   r_edge_cnt;
    logic [CNT_WIDTH:0]     w_cnt_ext;
    logic                   w_low;
    logic                   w_high;
    logic                   w_in_range;

    logic [CNT_WIDTH-1:0]   r_count_out;
    logic                   r_count_valid;
    logic                   r_freq_ok;
    logic                   r_freq_low;
    logic                   r_freq_high;
    logic                   r_stuck;

    // Only the first stage ever samples the raw asynchronous toggle.
    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], mon.meas_toggle};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge = r_sync[SYNC_STAGES-1] ^ r_sync_d;

    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = c_st_idle;
        case (r_state)
            c_st_idle:   w_state_next = mon.enable ? c_st_gate : c_st_idle;
            c_st_gate: begin
                if (!mon.enable) begin
                    w_state_next = c_st_idle;
                end else if (r_gate_cnt == c_gate_last) begin
                    w_state_next = c_st_report;
                end else begin
                    w_state_next = c_st_gate;
                end
            end
            c_st_report: w_state_next = mon.enable ? c_st_gate : c_st_idle;
            default:     w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_in_gate   = 1'b0;
        w_in_report = 1'b0;
        case (r_state)
            c_st_gate:   w_in_gate   = 1'b1;
            c_st_report: w_in_report = 1'b1;
            default:     ;
        endcase
    end

    // Counters run only while the window continues; abort and report both clear.
    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
        end else begin
            if (w_in_gate && (w_state_next == c_st_gate)) begin
                r_gate_cnt <= r_gate_cnt + c_gate_w'(1);
            end else begin
                r_gate_cnt <= '0;
            end

            if (w_in_gate && (w_state_next != c_st_idle)) begin
                if (w_edge && !(&r_edge_cnt)) begin
                    r_edge_cnt <= r_edge_cnt + CNT_WIDTH'(1);
                end
            end else begin
                r_edge_cnt <= '0;
            end
        end
    end

    assign w_cnt_ext  = {1'b0, r_edge_cnt};
    assign w_low      = (w_cnt_ext < c_exp_min);
    assign w_high     = (w_cnt_ext > c_exp_max);
    assign w_in_range = !w_low && !w_high;

    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_count_out   <= '0;
            r_count_valid <= 1'b0;
            r_freq_low    <= 1'b0;
            r_freq_high   <= 1'b0;
            r_stuck       <= 1'b0;
        end else begin
            r_count_valid <= w_in_report;
            if (w_in_report) begin
                r_count_out <= r_edge_cnt;
                r_freq_low  <= w_low;
                r_freq_high <= w_high;
                r_stuck     <= (r_edge_cnt == '0);
            end
        end
    end

`ifdef FREQ_MON_HYST_EN
    logic [1:0] r_hyst_cnt;

    // Counts consecutive reports that disagree with the current freq_ok.
    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_freq_ok  <= 1'b0;
            r_hyst_cnt <= 2'd0;
        end else if (w_in_report) begin
            if (w_in_range == r_freq_ok) begin
                r_hyst_cnt <= 2'd0;
            end else if (r_hyst_cnt == 2'd1) begin
                r_freq_ok  <= w_in_range;
                r_hyst_cnt <= 2'd0;
            end else begin
                r_hyst_cnt <= r_hyst_cnt + 2'd1;
            end
        end
    end
`else
    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_freq_ok <= 1'b0;
        end else if (w_in_report) begin
            r_freq_ok <= w_in_range;
        end
    end
`endif

    assign mon.count_out   = r_count_out;
    assign mon.count_valid = r_count_valid;
    assign mon.freq_ok     = r_freq_ok;
    assign mon.freq_low    = r_freq_low;
    assign mon.freq_high   = r_freq_high;
    assign mon.stuck       = r_stuck;

endmodule
`default_nettype wire

// File: tb/tb_clock_freq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_freq_monitor
// Brief    : Directed bench for clock_freq_monitor (8-bit and saturating 4-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_freq_monitor;

`ifdef FREQ_MON_HYST_EN
    localparam bit c_hyst = 1'b1;
`else
    localparam bit c_hyst = 1'b0;
`endif

    logic clk_125mhz = 1'b0;
    logic rst_n      = 1'b0;
    logic enable     = 1'b0;
    logic toggle     = 1'b0;
    int   tog_period = 0;
    int   tog_cnt    = 0;
    int   vectors    = 0;
    int   miscompares = 0;

    clock_freq_monitor_if #(.CNT_WIDTH(8)) mon_if ();
    clock_freq_monitor_if #(.CNT_WIDTH(4)) sml_if ();

    assign mon_if.enable      = enable;
    assign mon_if.meas_toggle = toggle;
    assign sml_if.enable      = enable;
    assign sml_if.meas_toggle = toggle;

    clock_freq_monitor #(
        .GATE_CYCLES(100), .CNT_WIDTH(8), .EXPECT_MIN(24), .EXPECT_MAX(26), .SYNC_STAGES(3)
    ) u_dut (
        .clk_125mhz(clk_125mhz),
        .rst_n     (rst_n),
        .mon       (mon_if)
    );

    clock_freq_monitor #(
        .GATE_CYCLES(100), .CNT_WIDTH(4), .EXPECT_MIN(4), .EXPECT_MAX(8), .SYNC_STAGES(3)
    ) u_dut_sml (
        .clk_125mhz(clk_125mhz),
        .rst_n     (rst_n),
        .mon       (sml_if)
    );

    always #4 clk_125mhz = ~clk_125mhz;

    // Toggle source; its phase restarts on each count_valid so window counts are exact.
    always begin
        @(posedge clk_125mhz);
        #1;
        if (mon_if.count_valid) begin
            tog_cnt = 0;
        end else if (tog_period > 0) begin
            if (tog_cnt >= tog_period - 1) begin
                toggle  = ~toggle;
                tog_cnt = 0;
            end else begin
                tog_cnt++;
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_main(input string tag, input int cnt, input int ok,
                              input int low, input int high, input int stk);
        check({tag, ".count_out"}, int'(mon_if.count_out), cnt);
        check({tag, ".freq_ok"},   int'(mon_if.freq_ok),   ok);
        check({tag, ".freq_low"},  int'(mon_if.freq_low),  low);
        check({tag, ".freq_high"}, int'(mon_if.freq_high), high);
        check({tag, ".stuck"},     int'(mon_if.stuck),     stk);
    endtask

    task automatic check_sml(input string tag, input int cnt, input int ok,
                             input int low, input int high, input int stk);
        check({tag, ".sml.count_out"}, int'(sml_if.count_out), cnt);
        check({tag, ".sml.freq_ok"},   int'(sml_if.freq_ok),   ok);
        check({tag, ".sml.freq_low"},  int'(sml_if.freq_low),  low);
        check({tag, ".sml.freq_high"}, int'(sml_if.freq_high), high);
        check({tag, ".sml.stuck"},     int'(sml_if.stuck),     stk);
    endtask

    task automatic wait_valid(input string tag, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk_125mhz);
            n++;
        end while (!mon_if.count_valid && n < limit);
        vectors++;
        assert (mon_if.count_valid === 1'b1) else begin
            miscompares++;
            $error("FAIL %s: observed no count_valid within %0d cycles, expected a pulse", tag, limit);
        end
    endtask

    initial begin
        int n;
        bit quiet;

        // Reset held
        repeat (5) @(negedge clk_125mhz);
        check("rst.count_valid", int'(mon_if.count_valid), 0);
        check_main("rst", 0, 0, 0, 0, 0);
        check_sml("rst", 0, 0, 0, 0, 0);

        // Released, enable low
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (500) begin
            @(negedge clk_125mhz);
            if (mon_if.count_valid !== 1'b0 || mon_if.count_out !== 8'd0 ||
                mon_if.freq_ok !== 1'b0 || mon_if.freq_low !== 1'b0 ||
                mon_if.freq_high !== 1'b0 || mon_if.stuck !== 1'b0)
                quiet = 1'b0;
        end
        check("idle.quiet", int'(quiet), 1);

        // Nominal: toggle every 4 cycles -> 25 edges per 100-cycle window
        tog_period = 4;
        enable     = 1'b1;
        wait_valid("nom.first", 300, n);
        check("nom.first.latency", n, 102);
        wait_valid("nom", 300, n);
        check("nom.period", n, 101);
        check_main("nom", 25, 1, 0, 0, 0);
        check_sml("nom", 15, 0, 0, 1, 0);

        // Slow windows: 13 (one nominal edge carried in), then 12
        tog_period = 8;
        wait_valid("slow1", 300, n);
        check("slow1.period", n, 101);
        check_main("slow1", 13, c_hyst ? 1 : 0, 1, 0, 0);
        wait_valid("slow2", 300, n);
        check_main("slow2", 12, 0, 1, 0, 0);

        // Recovery: 24 sits on the inclusive lower bound
        tog_period = 4;
        wait_valid("rec1", 300, n);
        check_main("rec1", 24, c_hyst ? 0 : 1, 0, 0, 0);
        wait_valid("rec2", 300, n);
        check_main("rec2", 25, 1, 0, 0, 0);

        // Fast: 49 then 50; small instance saturates at 15
        tog_period = 2;
        wait_valid("fast1", 300, n);
        check_main("fast1", 49, c_hyst ? 1 : 0, 0, 1, 0);
        wait_valid("fast2", 300, n);
        check_main("fast2", 50, 0, 0, 1, 0);
        check_sml("fast2", 15, 0, 0, 1, 0);

        // Stuck: two trailing edges land in the first window, then none
        tog_period = 0;
        wait_valid("stk1", 300, n);
        check_main("stk1", 2, 0, 1, 0, 0);
        wait_valid("stk2", 300, n);
        check_main("stk2", 0, 0, 1, 0, 1);
        check_sml("stk2", 0, 0, 1, 0, 1);

        // Abort at gate cycle 50: no report, outputs hold
        tog_period = 4;
        repeat (50) @(negedge clk_125mhz);
        enable = 1'b0;
        quiet  = 1'b1;
        repeat (300) begin
            @(negedge clk_125mhz);
            if (mon_if.count_valid !== 1'b0) quiet = 1'b0;
        end
        check("abort.no_valid", int'(quiet), 1);
        check_main("abort.hold", 0, 0, 1, 0, 1);

        // Re-enable: fresh full window
        enable = 1'b1;
        wait_valid("reen", 300, n);
        check("reen.latency", n, 102);

        enable = 1'b0;
        repeat (5) @(negedge clk_125mhz);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_freq_monitor.md
Name: clock_freq_monitor

Overview:
- Measures the frequency of a divided-down clock from another domain, counted against the local system clock.
- ClockGeneration produces the clocks; this block sits at the consuming end and checks that each one is actually running at rate.
- Each source domain drives one flop that toggles every N cycles; that toggle crosses into this block asynchronously.
- One instance per monitored clock; results feed status registers and the PLL/IBUF health indicators.

Parameters:
- GATE_CYCLES, 125000, measurement window length in clk_125mhz cycles (1 ms); legal range ≥ 4.
- CNT_WIDTH, 20, width of the edge counter and count_out.
- EXPECT_MIN, 0, lowest edge count per window treated as in range (inclusive).
- EXPECT_MAX, 2^CNT_WIDTH-1, highest edge count per window treated as in range (inclusive).
- SYNC_STAGES, 3, synchronizer depth for meas_toggle; legal range ≥ 2.

Ports:
- clk_125mhz  in  1  system clock; all logic is in this domain.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run measurements while high.
- meas_toggle  in  1  asynchronous toggle from the monitored domain.
- count_out  out  CNT_WIDTH  edge count of the last completed window.
- count_valid  out  1  one-cycle pulse when count_out updates.
- freq_ok  out  1  last window count is within [EXPECT_MIN, EXPECT_MAX].
- freq_low  out  1  last window count < EXPECT_MIN.
- freq_high  out  1  last window count > EXPECT_MAX.
- stuck  out  1  last window count was 0.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All synchronizer stages and the edge-detect flop clear to 0.
  - Gate counter and edge counter clear to 0; FSM goes to IDLE.
  - count_out=0, count_valid=0, freq_ok=0, freq_low=0, freq_high=0, stuck=0.
- Input path:
  - meas_toggle passes through SYNC_STAGES flops; nothing else touches the raw input.
  - Every change of the synchronized value, rising or falling, is one edge.
  - Edge detect compares the last synchronizer stage with a registered copy of it.
- FSM states: IDLE, GATE, REPORT.
  - IDLE: gate counter and edge counter held at 0. If enable=1, go to GATE next cycle.
  - GATE:
    - Gate counter increments each cycle.
    - Edge counter increments on each detected edge and saturates at all-ones; it never wraps.
    - The window is exactly GATE_CYCLES cycles in GATE.
    - On the cycle where gate counter = GATE_CYCLES-1, go to REPORT. An edge detected in that cycle counts into the closing window.
  - REPORT (one cycle):
    - Latch count_out ← edge counter.
    - Update freq_low, freq_high, freq_ok and stuck from the latched value.
    - Clear both counters.
    - Next state is GATE if enable=1, else IDLE.
    - An edge detected during REPORT is discarded.
- Output timing:
  - count_valid is registered. It is high for exactly the one cycle after REPORT, the cycle in which the new count_out and flags first appear.
  - Flags are registered and hold their value between reports.
- Flag rules:
  - freq_low, freq_high and freq_ok are mutually exclusive.
  - stuck=1 implies freq_low=1 whenever EXPECT_MIN > 0.
- enable deasserted during GATE:
  - Abort the window next cycle and go to IDLE; counters clear.
  - No REPORT, no count_valid. count_out and flags keep their last values.
- enable toggled during REPORT: only the next-state choice is affected; the report still completes.
- Re-enable after abort: a fresh, full-length window starts. Partial counts are never reused.

Optional Feature:
- Macro: FREQ_MON_HYST_EN.
- Defined:
  - A 2-bit consecutive-result counter filters freq_ok.
  - freq_ok falls only after 2 consecutive out-of-range reports.
  - freq_ok rises only after 2 consecutive in-range reports; from reset it first rises after 2 good windows.
  - freq_low, freq_high and stuck stay unfiltered, so freq_ok may disagree with them for one report.
- Undefined: freq_ok follows each report immediately, as described under Behaviour.

Test Plan:
All scenarios use GATE_CYCLES=100, CNT_WIDTH=8, EXPECT_MIN=24, EXPECT_MAX=26, SYNC_STAGES=3.
- Reset and idle: hold rst_n=0, then release with enable=0 for 500 cycles -> every output stays 0; count_valid never pulses.
- Nominal: enable=1; meas_toggle flips every 4 cycles -> count_valid pulses every 101 cycles; count_out ∈ {24, 25, 26}; freq_ok=1; low, high and stuck all 0.
- Slow and stuck:
  - meas_toggle flips every 8 cycles -> count_out ∈ {12, 13}; freq_low=1; freq_ok=0.
  - meas_toggle held constant -> count_out=0; stuck=1; freq_low=1.
- Fast and saturation:
  - meas_toggle flips every 2 cycles -> count_out ∈ {49, 50, 51}; freq_high=1.
  - Re-run with CNT_WIDTH=4 -> count_out=15 (saturated, no wrap); freq_high=1.
- Abort: drop enable at gate cycle 50 -> no count_valid; count_out and flags keep their prior values. Re-enable -> the next count_valid arrives 101 cycles after re-entering GATE.
- Hysteresis (FREQ_MON_HYST_EN): while nominal, make one window slow -> freq_low=1 but freq_ok stays 1. Make a second slow window -> freq_ok=0. Two nominal windows -> freq_ok=1. Without the macro, the first slow window already gives freq_ok=0.
